// File: rtl/encaixotamento_pkg.sv
// Shared constants for the box-packing stage.
// Holds the controller state encoding, the default parameter values and the
// timer width. There are no ports: the stage controller and the bench import
// this package.
package encaixotamento_pkg;

  // Default number of approved bottles that fill one box. Valid range is 2..15.
  localparam int unsigned GARRAFAS_POR_CAIXA_PADRAO = 12;

  // Default number of CLK cycles allowed for a box exchange before the alarm.
  localparam int unsigned TIMEOUT_TROCA_PADRAO = 50_000_000;

  // Width of the exchange timer. 26 bits covers the default timeout.
  localparam int unsigned TIMER_W = 26;

  // Controller states.
  localparam logic [1:0] ESPERA_CAIXA = 2'd0;  // conveyor runs, waiting for an empty box
  localparam logic [1:0] ENCHENDO     = 2'd1;  // box in position, accepting bottles
  localparam logic [1:0] CHEIA        = 2'd2;  // box full, conveyor carrying it away
  localparam logic [1:0] ALARME       = 2'd3;  // exchange timeout or box removed while filling

endpackage

// File: rtl/contador_bcd_caixas.sv
// Two-digit BCD counter of completed boxes.
// The counter advances by one on each clock edge where en_i is high. It wraps
// from 99 to 00.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset, clears both digits
//   en_i   - count enable, one cycle per completed box
//   un_o   - units digit, BCD 0..9
//   dez_o  - tens digit, BCD 0..9
module contador_bcd_caixas (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [3:0] un_o,
  output logic [3:0] dez_o
);

  logic [3:0] un_q, un_d;
  logic [3:0] dez_q, dez_d;

  always_comb begin
    un_d  = un_q;
    dez_d = dez_q;
    if (en_i) begin
      if (un_q == 4'd9) begin
        un_d  = 4'd0;
        dez_d = (dez_q == 4'd9) ? 4'd0 : dez_q + 4'd1;
      end else begin
        un_d = un_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      un_q  <= 4'd0;
      dez_q <= 4'd0;
    end else begin
      un_q  <= un_d;
      dez_q <= dez_d;
    end
  end

  assign un_o  = un_q;
  assign dez_o = dez_q;

endmodule

// File: rtl/mef_encaixotamento.sv
// Controller for the box-packing stage.
// The controller counts approved bottles into the current box. It closes the
// box when the box is full, runs the conveyor while a box is being exchanged,
// and raises an alarm on an exchange timeout or when the box is removed while
// it is being filled.
// Parameters:
//   GARRAFAS_POR_CAIXA - bottles per box (2..15)
//   TIMEOUT_TROCA      - cycles allowed in an exchange state before the alarm
// Ports:
//   CLK            - system clock, rising edge
//   reset          - asynchronous active-low reset
//   garrafaOk      - one-cycle pulse per approved bottle
//   caixaPresente  - debounced level, 1 = box in packing position
//   limpar         - one-cycle operator alarm acknowledge
//   prontoCaixa    - stage accepts bottles (filling)
//   motorCaixa     - box conveyor motor enable
//   caixaFechada   - one-cycle pulse after a box completes
//   garrafaPerdida - one-cycle pulse after a bottle that could not be accepted
//   alarmeCaixa    - alarm level
//   contaGarrafas  - bottles in the current box
//   caixasUn/Dez   - completed-box count, BCD 00..99
module mef_encaixotamento #(
  parameter int unsigned GARRAFAS_POR_CAIXA = encaixotamento_pkg::GARRAFAS_POR_CAIXA_PADRAO,
  parameter int unsigned TIMEOUT_TROCA      = encaixotamento_pkg::TIMEOUT_TROCA_PADRAO
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       garrafaOk,
  input  logic       caixaPresente,
  input  logic       limpar,
  output logic       prontoCaixa,
  output logic       motorCaixa,
  output logic       caixaFechada,
  output logic       garrafaPerdida,
  output logic       alarmeCaixa,
  output logic [3:0] contaGarrafas,
  output logic [3:0] caixasUn,
  output logic [3:0] caixasDez
);

  import encaixotamento_pkg::*;

  localparam logic [3:0]         ULTIMA = 4'(GARRAFAS_POR_CAIXA - 1);
  localparam logic [TIMER_W-1:0] LIMITE = TIMER_W'(TIMEOUT_TROCA - 1);

  logic [1:0]         estado_q, estado_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         conta_q, conta_d;
  logic               fechada_q, fechada_d;
  logic               perdida_q, perdida_d;
  logic               inc_caixa;

  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q;
    conta_d   = conta_q;
    fechada_d = 1'b0;
    inc_caixa = 1'b0;
    // A bottle is lost unless the stage is filling and the box is still there.
    // A removal in the same cycle therefore loses the bottle.
    perdida_d = garrafaOk && !((estado_q == ENCHENDO) && caixaPresente);

    unique case (estado_q)
      ESPERA_CAIXA: begin
        if (caixaPresente) begin
          estado_d = ENCHENDO;
        end else if (timer_q == LIMITE) begin
          estado_d = ALARME;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ENCHENDO: begin
        if (!caixaPresente) begin
          estado_d = ALARME;  // keep the partial count for the operator
        end else if (garrafaOk) begin
          if (conta_q == ULTIMA) begin
            conta_d   = 4'd0;
            inc_caixa = 1'b1;
            fechada_d = 1'b1;
            timer_d   = '0;
            estado_d  = CHEIA;
          end else begin
            conta_d = conta_q + 4'd1;
          end
        end
      end
      CHEIA: begin
        if (!caixaPresente) begin
          timer_d  = '0;
          estado_d = ESPERA_CAIXA;
        end else if (timer_q == LIMITE) begin
          estado_d = ALARME;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ALARME: begin
        if (limpar) begin
          conta_d  = 4'd0;
          timer_d  = '0;
          estado_d = ESPERA_CAIXA;
        end
      end
      default: estado_d = ESPERA_CAIXA;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      estado_q  <= ESPERA_CAIXA;
      timer_q   <= '0;
      conta_q   <= 4'd0;
      fechada_q <= 1'b0;
      perdida_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      conta_q   <= conta_d;
      fechada_q <= fechada_d;
      perdida_q <= perdida_d;
    end
  end

  contador_bcd_caixas u_contador_bcd (
    .clk_i  (CLK),
    .rst_ni (reset),
    .en_i   (inc_caixa),
    .un_o   (caixasUn),
    .dez_o  (caixasDez)
  );

  // The level outputs depend only on the state. The pulses are registered.
  assign prontoCaixa    = (estado_q == ENCHENDO);
  assign motorCaixa     = (estado_q == ESPERA_CAIXA) || (estado_q == CHEIA);
  assign alarmeCaixa    = (estado_q == ALARME);
  assign caixaFechada   = fechada_q;
  assign garrafaPerdida = perdida_q;
  assign contaGarrafas  = conta_q;

endmodule

// File: doc/mef_encaixotamento.md
MEF_ENCAIXOTAMENTO -- requirements
Module: mef_encaixotamento

Interface
REQ-001 SHALL have parameter GARRAFAS_POR_CAIXA, default 12, meaning approved bottles per box (range 2..15).
REQ-002 SHALL have parameter TIMEOUT_TROCA, default 50_000_000, meaning CLK cycles allowed for a box exchange before alarm.
REQ-003 SHALL have port CLK  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port garrafaOk  input  1  one-cycle pulse per approved bottle from quality control.
REQ-006 SHALL have port caixaPresente  input  1  debounced level, 1 = box in packing position.
REQ-007 SHALL have port limpar  input  1  one-cycle pulse, operator alarm acknowledge.
REQ-008 SHALL have port prontoCaixa  output  1  1 = stage accepts bottles.
REQ-009 SHALL have port motorCaixa  output  1  box conveyor motor enable.
REQ-010 SHALL have port caixaFechada  output  1  one-cycle pulse when a box completes.
REQ-011 SHALL have port garrafaPerdida  output  1  one-cycle pulse when a garrafaOk arrives while prontoCaixa = 0.
REQ-012 SHALL have port alarmeCaixa  output  1  exchange timeout or box removed while filling.
REQ-013 SHALL have port contaGarrafas  output  4  bottles in current box, 0..GARRAFAS_POR_CAIXA-1.
REQ-014 SHALL have ports caixasUn, caixasDez  output  4 each  completed-box count, BCD 00..99.

Function
REQ-015 SHALL implement states ESPERA_CAIXA, ENCHENDO, CHEIA, ALARME; outputs Moore except the pulses.
REQ-016 ESPERA_CAIXA: motorCaixa=1, prontoCaixa=0; caixaPresente=1 -> ENCHENDO next cycle.
REQ-017 ENCHENDO: motorCaixa=0, prontoCaixa=1; each garrafaOk increments contaGarrafas on the next edge.
REQ-018 ENCHENDO with garrafaOk and contaGarrafas = GARRAFAS_POR_CAIXA-1 SHALL clear contaGarrafas, increment BCD count, pulse caixaFechada the following cycle, go to CHEIA.
REQ-019 CHEIA: motorCaixa=1, prontoCaixa=0; caixaPresente=0 -> ESPERA_CAIXA.
REQ-020 A 26-bit timer SHALL clear on entry to CHEIA or ESPERA_CAIXA, count each cycle in them, and reaching TIMEOUT_TROCA-1 SHALL enter ALARME.
REQ-021 caixaPresente falling in ENCHENDO SHALL enter ALARME; contaGarrafas is held.
REQ-022 Simultaneous garrafaOk and caixaPresente=0 in ENCHENDO: removal wins, bottle not counted, garrafaPerdida pulses.
REQ-023 ALARME: motorCaixa=0, prontoCaixa=0, alarmeCaixa=1; limpar -> ESPERA_CAIXA with contaGarrafas cleared and alarm dropped.
REQ-024 BCD count SHALL wrap 99 -> 00 with no other effect.
REQ-025 garrafaPerdida SHALL be registered, one cycle after the offending garrafaOk.
REQ-026 limpar outside ALARME SHALL be ignored.

Reset
REQ-027 reset low SHALL immediately force state ESPERA_CAIXA, timer 0, contaGarrafas 0, BCD 00, all pulses 0, alarmeCaixa 0, prontoCaixa 0, motorCaixa 1.
REQ-028 reset asserted mid-box SHALL discard the partial count; no caixaFechada is issued.

Structure
REQ-029 State encoding and default parameter constants SHALL live in shared package encaixotamento_pkg.
REQ-030 The two-digit BCD counter SHALL be a sub-module contador_bcd_caixas (enable, wrap at 99, async active-low reset).

Verification
REQ-031 Box present, 12 garrafaOk pulses -> contaGarrafas 0..11 then 0, caixaFechada one pulse, caixasUn=1, state CHEIA, motorCaixa=1.
REQ-032 BCD 99, complete one box -> caixasDez=0, caixasUn=0.
REQ-033 TIMEOUT_TROCA=100, hold caixaPresente=1 in CHEIA -> alarmeCaixa=1 at cycle 100; limpar -> ESPERA_CAIXA, alarm 0.
REQ-034 After 5 bottles drop caixaPresente together with garrafaOk -> ALARME, contaGarrafas=5, garrafaPerdida one pulse.
REQ-035 garrafaOk in ESPERA_CAIXA -> garrafaPerdida pulse, count unchanged.
REQ-036 Assert reset after 7 bottles -> all outputs at reset values asynchronously, no caixaFechada.
